// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared types and encodings for the decode stage: op classes,
//                immediate formats and RV32 opcode/funct field constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

   // Op class presented downstream; NOP is the reset value
   typedef enum logic [3:0] {
      OP_NOP     = 4'd0,
      OP_ADD     = 4'd1,
      OP_SUB     = 4'd2,
      OP_ADDI    = 4'd3,
      OP_BEQ     = 4'd4,
      OP_BNE     = 4'd5,
      OP_LW      = 4'd6,
      OP_SW      = 4'd7,
      OP_LUI     = 4'd8,
      OP_JAL     = 4'd9,
      OP_ILLEGAL = 4'd15
   } op_t;

   // Immediate layout selector; NONE yields a zero immediate
   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_t;

   localparam logic [6:0] c_OPC_OP     = 7'b0110011;
   localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

   localparam logic [2:0] c_F3_ADD_SUB = 3'b000;
   localparam logic [2:0] c_F3_BEQ     = 3'b000;
   localparam logic [2:0] c_F3_BNE     = 3'b001;
   localparam logic [2:0] c_F3_WORD    = 3'b010;

   localparam logic [6:0] c_F7_ADD     = 7'b0000000;
   localparam logic [6:0] c_F7_SUB     = 7'b0100000;

endpackage
`default_nettype wire

// File: rtl/decode_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : decode_imm_gen
//  Description : Combinational immediate generator. Assembles the 32-bit
//                immediate for the selected format and sign-extends it from
//                instr[31] to XLEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr,
   input  imm_fmt_t        fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] w_imm32;

   // Reassemble immediate bits for each instruction format
   always_comb begin
      w_imm32 = '0;
      case (fmt)
         IMM_I:   w_imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   w_imm32 = {instr[31:12], 12'b0};
         IMM_J:   w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase
   end

   // A signed size cast carries instr[31] into the upper bits on XLEN=64
   assign imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Single-issue decode stage with a valid/ready skid buffer.
//                One output register plus one skid register keep in_ready a
//                pure flop output. Optional macro DECODE_BYPASS_EN adds a
//                writeback bypass port for source operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
   import decode_pkg::*;
#(
   parameter int  XLEN  = 32,
   parameter int  NREGS = 32,
   localparam int RW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
`ifdef DECODE_BYPASS_EN
   input  logic            wb_valid,
   input  logic [RW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
`endif
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] reg_file [NREGS],
   output logic            out_valid,
   input  logic            out_ready,
   output op_t             out_op,
   output logic [RW-1:0]   out_rd,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);

   typedef struct packed {
      op_t             op;
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic            illegal;
   } bundle_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FULL  = 2'd1,
      S_SKID  = 2'd2
   } state_t;

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   logic [31:0]     w_rs1_idx;
   logic [31:0]     w_rs2_idx;
   logic            w_rs1_oob;
   logic            w_rs2_oob;
   op_t             w_op;
   imm_fmt_t        w_fmt;
   logic            w_rd_en;
   logic            w_use_rs1;
   logic            w_use_rs2;
   logic [XLEN-1:0] w_imm;
   bundle_t         w_dec;
   logic            w_in_xfer;
   logic            w_out_xfer;

   state_t          r_state;
   bundle_t         r_out;
   bundle_t         r_skid;
   logic            r_in_ready;
   logic            r_out_valid;

   assign w_opcode  = in_instr[6:0];
   assign w_funct3  = in_instr[14:12];
   assign w_funct7  = in_instr[31:25];
   assign w_rs1_idx = {27'd0, in_instr[19:15]};
   assign w_rs2_idx = {27'd0, in_instr[24:20]};
   assign w_rs1_oob = (w_rs1_idx >= 32'(NREGS));
   assign w_rs2_oob = (w_rs2_idx >= 32'(NREGS));

   // Classify the instruction: op class, immediate format, register usage
   always_comb begin
      w_op      = OP_ILLEGAL;
      w_fmt     = IMM_NONE;
      w_rd_en   = 1'b0;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      case (w_opcode)
         c_OPC_OP: begin
            if (w_funct3 == c_F3_ADD_SUB && w_funct7 == c_F7_ADD) begin
               w_op = OP_ADD; w_rd_en = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end else if (w_funct3 == c_F3_ADD_SUB && w_funct7 == c_F7_SUB) begin
               w_op = OP_SUB; w_rd_en = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
         end
         c_OPC_OP_IMM: begin
            if (w_funct3 == c_F3_ADD_SUB) begin
               w_op = OP_ADDI; w_fmt = IMM_I; w_rd_en = 1'b1; w_use_rs1 = 1'b1;
            end
         end
         c_OPC_BRANCH: begin
            if (w_funct3 == c_F3_BEQ) begin
               w_op = OP_BEQ; w_fmt = IMM_B; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end else if (w_funct3 == c_F3_BNE) begin
               w_op = OP_BNE; w_fmt = IMM_B; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
         end
         c_OPC_LOAD: begin
            if (w_funct3 == c_F3_WORD) begin
               w_op = OP_LW; w_fmt = IMM_I; w_rd_en = 1'b1; w_use_rs1 = 1'b1;
            end
         end
         c_OPC_STORE: begin
            if (w_funct3 == c_F3_WORD) begin
               w_op = OP_SW; w_fmt = IMM_S; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
         end
         c_OPC_LUI: begin
            w_op = OP_LUI; w_fmt = IMM_U; w_rd_en = 1'b1;
         end
         c_OPC_JAL: begin
            w_op = OP_JAL; w_fmt = IMM_J; w_rd_en = 1'b1;
         end
         default: ;
      endcase
   end

   decode_imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .instr (in_instr[31:7]),
      .fmt   (w_fmt),
      .imm   (w_imm)
   );

   // Read operands (x0 and out-of-range addresses read zero) and assemble the bundle
   always_comb begin
      w_dec = '0;
      for (int i = 1; i < NREGS; i++) begin
         if (w_rs1_idx == 32'(i)) w_dec.rs1_data = reg_file[i];
         if (w_rs2_idx == 32'(i)) w_dec.rs2_data = reg_file[i];
      end
`ifdef DECODE_BYPASS_EN
      // A same-cycle writeback to a source register overrides the stale array value
      if (wb_valid && wb_rd != '0 && !w_rs1_oob && w_rs1_idx == 32'(wb_rd)) w_dec.rs1_data = wb_data;
      if (wb_valid && wb_rd != '0 && !w_rs2_oob && w_rs2_idx == 32'(wb_rd)) w_dec.rs2_data = wb_data;
`else
      // Operands come from the register array only
`endif
      w_dec.op      = w_op;
      w_dec.rd      = w_rd_en ? RW'({27'd0, in_instr[11:7]}) : '0;
      w_dec.imm     = w_imm;
      w_dec.pc      = in_pc;
      w_dec.illegal = (w_op == OP_ILLEGAL) || (w_use_rs1 && w_rs1_oob) || (w_use_rs2 && w_rs2_oob);
   end

   assign w_in_xfer  = in_valid && r_in_ready;
   assign w_out_xfer = r_out_valid && out_ready;

   // Skid-buffer FSM; handshake flags are registered alongside the state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_EMPTY;
         r_out       <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_xfer) begin
                  r_out       <= w_dec;
                  r_out_valid <= 1'b1;
                  r_state     <= S_FULL;
               end
            end
            S_FULL: begin
               if (w_in_xfer && w_out_xfer) begin
                  r_out <= w_dec;
               end else if (w_in_xfer) begin
                  r_skid     <= w_dec;
                  r_in_ready <= 1'b0;
                  r_state    <= S_SKID;
               end else if (w_out_xfer) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_EMPTY;
               end
            end
            S_SKID: begin
               if (w_out_xfer) begin
                  r_out      <= r_skid;
                  r_in_ready <= 1'b1;
                  r_state    <= S_FULL;
               end
            end
            default: begin
               r_state     <= S_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_op       = r_out.op;
   assign out_rd       = r_out.rd;
   assign out_rs1_data = r_out.rs1_data;
   assign out_rs2_data = r_out.rs2_data;
   assign out_imm      = r_out.imm;
   assign out_pc       = r_out.pc;
   assign out_illegal  = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage. Build with
//                DECODE_BYPASS_EN defined to also exercise the bypass port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
   import decode_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int RW    = 5;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] reg_file [NREGS];
   logic            out_valid;
   logic            out_ready;
   op_t             out_op;
   logic [RW-1:0]   out_rd;
   logic [XLEN-1:0] out_rs1_data;
   logic [XLEN-1:0] out_rs2_data;
   logic [XLEN-1:0] out_imm;
   logic [XLEN-1:0] out_pc;
   logic            out_illegal;
`ifdef DECODE_BYPASS_EN
   logic            wb_valid;
   logic [RW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
`endif

   int tests_run;
   int tests_failed;

   decode_stage #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
`ifdef DECODE_BYPASS_EN
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
`endif
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .reg_file     (reg_file),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_op       (out_op),
      .out_rd       (out_rd),
      .out_rs1_data (out_rs1_data),
      .out_rs2_data (out_rs2_data),
      .out_imm      (out_imm),
      .out_pc       (out_pc),
      .out_illegal  (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just past the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      tests_run++; if (out_op !== OP_NOP) begin tests_failed++; $display("FAIL reset_out_op: got %0d want 0", out_op); end
      tests_run++; if (out_illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_out_illegal: got %0b want 0", out_illegal); end
      tests_run++; if ({out_rd, out_rs1_data, out_rs2_data, out_imm, out_pc} !== '0) begin tests_failed++; $display("FAIL reset_data: got rd=%0h rs1=%0h rs2=%0h imm=%0h pc=%0h want all 0", out_rd, out_rs1_data, out_rs2_data, out_imm, out_pc); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h002081B3;
      in_pc     = 32'h0000_0100;
      step();
      in_valid = 1'b0;
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL add_valid: got %0b want 1", out_valid); end
      tests_run++; if (out_op !== OP_ADD) begin tests_failed++; $display("FAIL add_op: got %0d want %0d", out_op, OP_ADD); end
      tests_run++; if (out_rs1_data !== 32'd5 || out_rs2_data !== 32'd7) begin tests_failed++; $display("FAIL add_operands: got %0h/%0h want 5/7", out_rs1_data, out_rs2_data); end
      tests_run++; if (out_rd !== 5'd3 || out_imm !== 32'd0 || out_illegal !== 1'b0) begin tests_failed++; $display("FAIL add_rd_imm: got rd=%0d imm=%0h ill=%0b want 3/0/0", out_rd, out_imm, out_illegal); end
      tests_run++; if (out_pc !== 32'h100) begin tests_failed++; $display("FAIL add_pc: got %0h want 100", out_pc); end
      step();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL add_drain: got out_valid=%0b want 0", out_valid); end
   endtask

   task automatic test_x0_read();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h000001B3;
      step();
      in_valid = 1'b0;
      tests_run++; if (out_rs1_data !== 32'd0 || out_rs2_data !== 32'd0) begin tests_failed++; $display("FAIL x0_read: got %0h/%0h want 0/0", out_rs1_data, out_rs2_data); end
      step();
   endtask

   task automatic test_decode_table();
      logic [31:0] t_instr [10];
      op_t         t_op    [10];
      logic [31:0] t_imm   [10];
      logic [4:0]  t_rd    [10];
      logic [31:0] t_rs1   [10];
      logic [31:0] t_rs2   [10];
      logic        t_ill   [10];
      t_instr[0] = 32'hFE000EE3; t_op[0] = OP_BEQ;     t_imm[0] = 32'hFFFFFFFC; t_rd[0] = 5'd0; t_rs1[0] = 32'd0; t_rs2[0] = 32'd0; t_ill[0] = 1'b0;
      t_instr[1] = 32'h402081B3; t_op[1] = OP_SUB;     t_imm[1] = 32'h00000000; t_rd[1] = 5'd3; t_rs1[1] = 32'd5; t_rs2[1] = 32'd7; t_ill[1] = 1'b0;
      t_instr[2] = 32'hFFF00293; t_op[2] = OP_ADDI;    t_imm[2] = 32'hFFFFFFFF; t_rd[2] = 5'd5; t_rs1[2] = 32'd0; t_rs2[2] = 32'd0; t_ill[2] = 1'b0;
      t_instr[3] = 32'h00812203; t_op[3] = OP_LW;      t_imm[3] = 32'h00000008; t_rd[3] = 5'd4; t_rs1[3] = 32'd7; t_rs2[3] = 32'd0; t_ill[3] = 1'b0;
      t_instr[4] = 32'hFE20AE23; t_op[4] = OP_SW;      t_imm[4] = 32'hFFFFFFFC; t_rd[4] = 5'd0; t_rs1[4] = 32'd5; t_rs2[4] = 32'd7; t_ill[4] = 1'b0;
      t_instr[5] = 32'h00209863; t_op[5] = OP_BNE;     t_imm[5] = 32'h00000010; t_rd[5] = 5'd0; t_rs1[5] = 32'd5; t_rs2[5] = 32'd7; t_ill[5] = 1'b0;
      t_instr[6] = 32'h123450B7; t_op[6] = OP_LUI;     t_imm[6] = 32'h12345000; t_rd[6] = 5'd1; t_rs1[6] = 32'd0; t_rs2[6] = 32'd0; t_ill[6] = 1'b0;
      t_instr[7] = 32'h008000EF; t_op[7] = OP_JAL;     t_imm[7] = 32'h00000008; t_rd[7] = 5'd1; t_rs1[7] = 32'd0; t_rs2[7] = 32'd0; t_ill[7] = 1'b0;
      t_instr[8] = 32'hFFFFFFFF; t_op[8] = OP_ILLEGAL; t_imm[8] = 32'h00000000; t_rd[8] = 5'd0; t_rs1[8] = 32'd0; t_rs2[8] = 32'd0; t_ill[8] = 1'b1;
      t_instr[9] = 32'h202081B3; t_op[9] = OP_ILLEGAL; t_imm[9] = 32'h00000000; t_rd[9] = 5'd0; t_rs1[9] = 32'd5; t_rs2[9] = 32'd7; t_ill[9] = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_instr = t_instr[i];
         in_pc    = 32'h1000 + 32'(4 * i);
         step();
         tests_run++;
         if (out_valid !== 1'b1 || out_op !== t_op[i] || out_imm !== t_imm[i] || out_rd !== t_rd[i] ||
             out_rs1_data !== t_rs1[i] || out_rs2_data !== t_rs2[i] || out_illegal !== t_ill[i] || out_pc !== 32'h1000 + 32'(4 * i)) begin
            tests_failed++;
            $display("FAIL decode[%0d] %h: got v=%0b op=%0d imm=%h rd=%0d rs1=%h rs2=%h ill=%0b pc=%h want v=1 op=%0d imm=%h rd=%0d rs1=%h rs2=%h ill=%0b pc=%h",
                     i, t_instr[i], out_valid, out_op, out_imm, out_rd, out_rs1_data, out_rs2_data, out_illegal, out_pc,
                     t_op[i], t_imm[i], t_rd[i], t_rs1[i], t_rs2[i], t_ill[i], 32'h1000 + 32'(4 * i));
         end
      end
      in_valid = 1'b0;
      step();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL table_drain: got out_valid=%0b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [31:0] tbl [4];
      int          n_in;
      int          n_out;
      int          first_stall;
      logic        held_v;
      logic [31:0] held;
      for (int k = 0; k < 4; k++) tbl[k] = (32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13;
      n_in = 0; n_out = 0; first_stall = -1; held_v = 1'b0; held = '0;
      in_valid = 1'b1;
      in_instr = tbl[0];
      for (int c = 0; c < 30 && n_out < 4; c++) begin
         if (held_v) begin
            tests_run++; if (out_valid !== 1'b1 || out_imm !== held) begin tests_failed++; $display("FAIL bp_stable: got v=%0b imm=%h want v=1 imm=%h", out_valid, out_imm, held); end
         end
         out_ready = (c >= 3);
         if (out_valid && out_ready) begin
            tests_run++; if (out_imm !== 32'(n_out + 1)) begin tests_failed++; $display("FAIL bp_order: got imm=%0d want %0d", out_imm, n_out + 1); end
            n_out++;
         end
         held_v = out_valid && !out_ready;
         held   = out_imm;
         if (!in_ready && first_stall < 0) first_stall = n_in;
         if (in_valid && in_ready) n_in++;
         step();
         in_valid = (n_in < 4);
         if (n_in < 4) in_instr = tbl[n_in];
      end
      tests_run++; if (first_stall !== 2) begin tests_failed++; $display("FAIL bp_stall_point: got %0d accepted before in_ready fell want 2", first_stall); end
      tests_run++; if (n_out !== 4 || n_in !== 4) begin tests_failed++; $display("FAIL bp_count: got in=%0d out=%0d want 4/4", n_in, n_out); end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got out_valid=%0b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_skid();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h002081B3;
      step();
      in_instr  = 32'h402081B3;
      step();
      in_valid  = 1'b0;
      tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL skid_setup: got in_ready=%0b out_valid=%0b want 0/1", in_ready, out_valid); end
      #1 rst = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_async: got out_valid=%0b want 0", out_valid); end
      step();
      tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_op !== OP_NOP) begin tests_failed++; $display("FAIL rst_mid_skid: got v=%0b rdy=%0b op=%0d want 0/1/0", out_valid, in_ready, out_op); end
      rst       = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h123450B7;
      step();
      in_valid = 1'b0;
      tests_run++; if (out_valid !== 1'b1 || out_op !== OP_LUI || out_imm !== 32'h12345000) begin tests_failed++; $display("FAIL rst_first_accept: got v=%0b op=%0d imm=%h want 1/%0d/12345000", out_valid, out_op, out_imm, OP_LUI); end
      step();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_discard: got out_valid=%0b want 0", out_valid); end
   endtask

`ifdef DECODE_BYPASS_EN
   task automatic test_bypass();
      wb_valid  = 1'b1;
      wb_rd     = 5'd1;
      wb_data   = 32'hAA;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h001081B3;
      step();
      in_valid = 1'b0;
      wb_valid = 1'b0;
      tests_run++; if (out_rs1_data !== 32'hAA || out_rs2_data !== 32'hAA) begin tests_failed++; $display("FAIL bypass: got %h/%h want aa/aa", out_rs1_data, out_rs2_data); end
      wb_valid = 1'b1;
      wb_rd    = 5'd0;
      in_valid = 1'b1;
      in_instr = 32'h000001B3;
      step();
      in_valid = 1'b0;
      wb_valid = 1'b0;
      tests_run++; if (out_rs1_data !== 32'd0) begin tests_failed++; $display("FAIL bypass_x0: got %h want 0", out_rs1_data); end
      step();
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      for (int r = 0; r < NREGS; r++) reg_file[r] = '0;
      reg_file[0] = 32'hDEADBEEF;
      reg_file[1] = 32'd5;
      reg_file[2] = 32'd7;
`ifdef DECODE_BYPASS_EN
      wb_valid = 1'b0;
      wb_rd    = '0;
      wb_data  = '0;
`endif
      #2;
      test_reset();
      test_add();
      test_x0_read();
      test_decode_table();
      test_backpressure();
      test_reset_mid_skid();
`ifdef DECODE_BYPASS_EN
      test_bypass();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Hard stop if the sequence ever stalls
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of register data, PC and immediates; legal values 32 and 64.
REQ-002 Parameter NREGS, default 32, register-file depth; register address width RW = clog2(NREGS).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  upstream instruction valid.
REQ-006 in_ready  out  1  stage can accept; driven directly from a flop, no combinational path from out_ready.
REQ-007 in_instr  in  32  instruction word.
REQ-008 in_pc  in  XLEN  instruction address.
REQ-009 reg_file  in  XLEN x NREGS  architectural register array.
REQ-010 out_valid  out  1  decoded bundle valid.
REQ-011 out_ready  in  1  downstream accepts when high.
REQ-012 out_op  out  4  op class (decode_pkg::op_t).
REQ-013 out_rd  out  RW  destination register.
REQ-014 out_rs1_data, out_rs2_data  out  XLEN each  source operands.
REQ-015 out_imm  out  XLEN  sign-extended immediate.
REQ-016 out_pc  out  XLEN  registered in_pc.
REQ-017 out_illegal  out  1  unsupported encoding.

Function
REQ-018 Transfer on a port occurs in a cycle where valid and ready are both high; latency in_instr -> out_* is exactly 1 cycle when the stage is empty.
REQ-019 Storage: one output register plus one skid register; FSM states EMPTY, FULL, SKID.
REQ-020 EMPTY: input transfer -> FULL. FULL: input transfer and output transfer -> FULL (output reloaded); input transfer only -> SKID; output transfer only -> EMPTY. SKID: output transfer -> FULL (skid moves to output).
REQ-021 in_ready = 1 in EMPTY and FULL, 0 in SKID; no instruction is dropped or duplicated under any out_ready pattern.
REQ-022 out_valid = 1 in FULL and SKID; out_* stay stable while out_valid=1 and out_ready=0.
REQ-023 Decoded ops: ADD (0110011/000/0000000), SUB (0110011/000/0100000), ADDI (0010011/000), BEQ (1100011/000), BNE (1100011/001), LW (0000011/010), SW (0100011/010), LUI (0110111), JAL (1101111); anything else -> op ILLEGAL, out_illegal=1, out_imm=0, bundle still passed downstream.
REQ-024 Immediates: I-type for ADDI/LW, S-type for SW, B-type for BEQ/BNE (bit0=0), U-type for LUI (low 12 bits 0), J-type for JAL (bit0=0); sign-extended from instr[31] to XLEN; R-type -> 0.
REQ-025 Operand read samples reg_file in the capture cycle; address 0 reads 0 regardless of reg_file[0]; address >= NREGS reads 0 and sets out_illegal.
REQ-026 out_rd = instr[11:7] for ADD/SUB/ADDI/LW/LUI/JAL, 0 otherwise.

Reset
REQ-027 On rst low: FSM = EMPTY, out_valid=0, in_ready=1, out_op=NOP(0), out_illegal=0, all data outputs 0, skid register cleared.
REQ-028 Reset asserted mid-transfer discards both held instructions; first cycle after release accepts new input.

Configuration
REQ-029 Macro DECODE_BYPASS_EN: when defined, adds ports wb_valid (1), wb_rd (RW), wb_data (XLEN); a capture with wb_valid=1, wb_rd!=0 and wb_rd matching rs1/rs2 uses wb_data for that operand; when undefined ports are absent and operands come from reg_file only.

Structure
REQ-030 decode_pkg holds op_t enum, opcode/funct3/funct7 localparams and imm_fmt_t; sub-module decode_imm_gen (combinational immediate generator, parameter XLEN).

Verification
REQ-031 Reset: rst low mid-SKID -> next cycle out_valid=0, in_ready=1, out_op=0.
REQ-032 ADD x3,x1,x2 (0x002081B3) with x1=5, x2=7, out_ready=1 -> one cycle later out_op=ADD, rs1=5, rs2=7, rd=3.
REQ-033 BEQ 0xFE000EE3 -> out_op=BEQ, out_imm=0xFFFFFFFC (XLEN=32).
REQ-034 Backpressure: stream 4 instrs, out_ready=0 for 3 cycles -> in_ready falls after 2 accepted, outputs in order, none lost.
REQ-035 Illegal 0xFFFFFFFF -> out_illegal=1, out_imm=0, out_valid=1.
REQ-036 DECODE_BYPASS_EN: wb_valid=1, wb_rd=1, wb_data=0xAA, reg_file[1]=5, decode ADD x3,x1,x1 -> rs1=rs2=0xAA.
